mux2_share_arb: RTL

//  Shares one 2:1 mux datapath (MUX2X1 slice per bit) between two valid/ready requesters A and B.

---
 rtl/mux2_share_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux2_share_arb.sv
// mux2_share_arb
//   Shares one inverting 2:1 mux datapath between two valid/ready requesters
//   (A and B) and registers the selected word into a single-entry output
//   stage. Arbitration is burst-limited round-robin. The current owner keeps
//   the grant for up to MAX_BURST consecutive words while the other side is
//   requesting. After that limit, ownership passes to the other side.
//
// Parameters
//   WIDTH      data width of a_data_i, b_data_i and y_data_o
//   MAX_BURST  max consecutive grants to one owner under contention (>= 1)
//
// Ports
//   clk_i      clock, rising edge
//   rn_i       synchronous active-low reset
//   a_valid_i  requester A has a word
//   a_data_i   requester A word
//   a_ready_o  A word accepted this cycle
//   b_valid_i  requester B has a word
//   b_data_i   requester B word
//   b_ready_o  B word accepted this cycle
//   sel_o      mux select (0=A, 1=B); follows the grant, holds owner when idle
//   y_valid_o  output register holds a word
//   y_data_o   registered output word (true polarity)
//   y_src_o    source of y_data_o (0=A, 1=B)
//   y_ready_i  consumer accepts the output word this cycle
module mux2_share_arb #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rn_i,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             sel_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  output logic             y_src_o,
  input  logic             y_ready_i
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_src_q, y_src_d;

  logic             load;
  logic             own_v, oth_v;
  logic             keep;
  logic             grant;
  logic             gidx;
  logic             sel;
  logic [WIDTH-1:0] mux_n;
  logic [WIDTH-1:0] mux_word;

  // The output stage can take a new word when it is empty or being drained.
  assign load  = ~y_valid_q | y_ready_i;
  assign own_v = owner_q ? b_valid_i : a_valid_i;
  assign oth_v = owner_q ? a_valid_i : b_valid_i;

  // The owner keeps the grant unless the other side is waiting and the
  // burst limit has been reached. If the owner is idle, the other side wins.
  assign keep  = own_v & (~oth_v | (cnt_q < CNT_MAX));
  assign grant = rn_i & load & (a_valid_i | b_valid_i);
  assign gidx  = keep ? owner_q : ~owner_q;
  assign sel   = grant ? gidx : owner_q;

  assign a_ready_o = grant & ~gidx;
  assign b_ready_o = grant &  gidx;
  assign sel_o     = sel;

  // One inverting mux slice per bit. Its output is inverted again so that
  // the registered word keeps its true polarity.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    assign mux_n[i] = ~(sel ? b_data_i[i] : a_data_i[i]);
  end
  assign mux_word = ~mux_n;

  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_src_d   = y_src_q;
    if (grant) begin
      if (keep) begin
        // Saturate so that a late requester can take over at the next load.
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
      end else begin
        owner_d = ~owner_q;
        cnt_d   = CNT_ONE;
      end
      y_valid_d = 1'b1;
      y_data_d  = mux_word;
      y_src_d   = gidx;
    end else if (load) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_src_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_src_q   <= y_src_d;
    end
  end

  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign y_src_o   = y_src_q;

endmodule
